// File: rtl/sram_bank_array.sv
// sram_bank_array: banked word SRAM with masked writes, registered read pipeline and zero-fill sweep
module sram_bank_array #(
   parameter int ROWS         = 64,
   parameter int COLS         = 64,
   parameter int DATA_WIDTH   = 8,
   parameter int NUM_BANKS    = 2,
   parameter int READ_LATENCY = 1,
   localparam int GROUPS      = COLS / DATA_WIDTH,
   localparam int ADDR_W      = $clog2(NUM_BANKS * ROWS * GROUPS)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_write,
   input  logic [ADDR_W-1:0]     req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   input  logic [DATA_WIDTH-1:0] req_wmask,
   input  logic                  clr_req,
   output logic                  rd_valid,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  init_done
);
   localparam int WPR   = GROUPS * NUM_BANKS;
   localparam int WPR_W = $clog2(WPR);
   localparam int RW    = $clog2(ROWS);
   typedef enum logic [1:0] {INIT, IDLE, CLEAR} state_t;
   state_t state, state_nx;
   logic [RW-1:0] row, row_nx;
   logic init_nx, sweep, accept, rd_acc;
   logic v1, v2;
   logic [DATA_WIDTH-1:0] d1, d2;
   logic [DATA_WIDTH-1:0] mem [NUM_BANKS*ROWS*GROUPS];
   assign sweep     = state != IDLE;
   assign req_ready = state == IDLE && !clr_req;
   assign accept    = req_valid && req_ready;
   assign rd_acc    = accept && !req_write;
   always_comb begin
      state_nx = state;
      row_nx   = row;
      init_nx  = init_done;
      if (sweep) begin
         row_nx = row + 1'b1;
         if (row == RW'(ROWS - 1)) begin
            state_nx = IDLE;
            init_nx  = init_done || state == INIT;
         end
      end else if (clr_req) begin
         state_nx = CLEAR;
         row_nx   = '0;
      end
   end
   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= INIT;
         row       <= '0;
         init_done <= 1'b0;
      end else begin
         state     <= state_nx;
         row       <= row_nx;
         init_done <= init_nx;
      end
   end
   // a sweep zeroes every group of the current row in all banks in one cycle
   always_ff @(posedge clk) begin
      if (rst) begin
         if (sweep)
            for (int i = 0; i < WPR; i++) mem[{row, WPR_W'(i)}] <= '0;
         else if (accept && req_write)
            mem[req_addr] <= (mem[req_addr] & ~req_wmask) | (req_wdata & req_wmask);
      end
   end
   always_ff @(posedge clk) begin
      if (!rst) begin
         v1 <= 1'b0;
         v2 <= 1'b0;
         d1 <= '0;
         d2 <= '0;
      end else begin
         v1 <= rd_acc;
         v2 <= v1;
         if (rd_acc) d1 <= mem[req_addr];
         if (v1) d2 <= d1;
      end
   end
   assign rd_valid = READ_LATENCY == 2 ? v2 : v1;
   assign rd_data  = READ_LATENCY == 2 ? d2 : d1;
endmodule
